// File: rtl/eeprom_save_bridge.sv
// -----------------------------------------------------------------------------
// eeprom_save_bridge
//
// Purpose:
//   Moves save data between the host's 32-bit data bridge and the EEPROM's
//   8-bit backdoor port. A host word write is serialised into four
//   consecutive byte writes. A host word read is serialised into four byte
//   reads, which are reassembled little-endian. A sticky dirty flag records
//   game-side EEPROM commits so the platform knows when the save needs a flush.
//
// Ports:
//   clk            in   system clock (also the EEPROM backdoor clock)
//   reset_n        in   asynchronous active-low reset
//   bridge_wr      in   word write request (accepted only when idle)
//   bridge_rd      in   word read request (accepted only when idle; write wins)
//   bridge_addr    in   byte address, bits [1:0] ignored
//   bridge_wr_data in   write word, [7:0] goes to addr+0
//   bridge_rd_data out  assembled read word, valid while rd_valid=1
//   rd_valid       out  one-cycle pulse when a read completes
//   busy           out  high while a transfer is in progress
//   rom_we         out  EEPROM backdoor write enable
//   rom_address    out  EEPROM backdoor byte address
//   rom_wdata      out  EEPROM backdoor write byte
//   rom_rdata      in   EEPROM backdoor read byte, RD_LAT cycles after address
//   eeprom_we      in   game-side EEPROM commit strobe
//   dirty_clear    in   host acknowledges a flush
//   dirty          out  sticky modified-since-clear flag
// -----------------------------------------------------------------------------
module eeprom_save_bridge #(
    parameter int ADDR_W = 13,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bridge_wr,
    input  logic              bridge_rd,
    input  logic [ADDR_W-1:0] bridge_addr,
    input  logic [31:0]       bridge_wr_data,
    output logic [31:0]       bridge_rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_address,
    output logic [7:0]        rom_wdata,
    input  logic [7:0]        rom_rdata,
    input  logic              eeprom_we,
    input  logic              dirty_clear,
    output logic              dirty
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD      = 2'd2,
        ST_RD_DONE = 2'd3
    } state_t;

    // Read counter value at which the final byte (byte 3) is captured.
    localparam logic [2:0] LP_LAST_RC = 3'(3 + RD_LAT);

    state_t            r_state;
    logic [1:0]        r_idx;
    logic [2:0]        r_rc;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_word;
    logic [31:0]       r_rd_data;
    logic              r_rd_valid;
    logic              r_rom_we;
    logic [ADDR_W-1:0] r_rom_address;
    logic [7:0]        r_rom_wdata;
    logic              r_dirty;

    logic [ADDR_W-1:0] w_base_in;
    logic [1:0]        w_idx_next;
    logic [1:0]        w_cap_idx;

    // Word-aligned base: the low two address bits are masked off.
    assign w_base_in  = bridge_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign w_idx_next = r_idx + 2'd1;
    // Byte lane being captured: the address issued RD_LAT cycles ago.
    assign w_cap_idx  = r_rc[1:0] - 2'(RD_LAT);

    // Transfer FSM. rom_* outputs are registered and loaded with the value
    // for the coming cycle, so the first byte access appears the cycle
    // right after the request is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= 2'd0;
            r_rc          <= 3'd0;
            r_base        <= '0;
            r_word        <= 32'd0;
            r_rd_data     <= 32'd0;
            r_rd_valid    <= 1'b0;
            r_rom_we      <= 1'b0;
            r_rom_address <= '0;
            r_rom_wdata   <= 8'd0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bridge_wr) begin
                        // Write wins over a simultaneous read.
                        r_base        <= w_base_in;
                        r_word        <= bridge_wr_data;
                        r_idx         <= 2'd0;
                        r_state       <= ST_WR;
                        r_rom_we      <= 1'b1;
                        r_rom_address <= w_base_in;
                        r_rom_wdata   <= bridge_wr_data[7:0];
                    end else if (bridge_rd) begin
                        r_base        <= w_base_in;
                        r_rc          <= 3'd0;
                        r_state       <= ST_RD;
                        r_rom_we      <= 1'b0;
                        r_rom_address <= w_base_in;
                    end
                end

                ST_WR: begin
                    r_idx <= w_idx_next;
                    if (r_idx == 2'd3) begin
                        r_state  <= ST_IDLE;
                        r_rom_we <= 1'b0;
                    end else begin
                        r_rom_we      <= 1'b1;
                        r_rom_address <= r_base + ADDR_W'(w_idx_next);
                        r_rom_wdata   <= r_word[{w_idx_next, 3'b000} +: 8];
                    end
                end

                ST_RD: begin
                    r_rom_we <= 1'b0;
                    if (r_rc < 3'd3) begin
                        r_rom_address <= r_base + ADDR_W'(r_rc + 3'd1);
                    end
                    if (r_rc >= 3'(RD_LAT)) begin
                        r_rd_data[{w_cap_idx, 3'b000} +: 8] <= rom_rdata;
                    end
                    if (r_rc == LP_LAST_RC) begin
                        r_state    <= ST_RD_DONE;
                        r_rd_valid <= 1'b1;
                    end
                    r_rc <= r_rc + 3'd1;
                end

                ST_RD_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_rom_we <= 1'b0;
                end
            endcase
        end
    end

    // Sticky dirty flag: a game commit in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dirty <= 1'b0;
        end else if (eeprom_we) begin
            r_dirty <= 1'b1;
        end else if (dirty_clear) begin
            r_dirty <= 1'b0;
        end
    end

    assign busy           = (r_state != ST_IDLE);
    assign rd_valid       = r_rd_valid;
    assign bridge_rd_data = r_rd_data;
    assign rom_we         = r_rom_we;
    assign rom_address    = r_rom_address;
    assign rom_wdata      = r_rom_wdata;
    assign dirty          = r_dirty;

endmodule

// File: tb/tb_eeprom_save_bridge.sv
// -----------------------------------------------------------------------------
// tb_eeprom_save_bridge
//
// Self-checking bench for eeprom_save_bridge. A behavioural EEPROM with a
// one-cycle registered read sits on the backdoor port. Expected read words
// come from a byte-array image of the save that the bench updates whenever it
// issues a write.
// -----------------------------------------------------------------------------
module tb_eeprom_save_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        bridge_wr;
    logic        bridge_rd;
    logic [12:0] bridge_addr;
    logic [31:0] bridge_wr_data;
    logic [31:0] bridge_rd_data;
    logic        rd_valid;
    logic        busy;
    logic        rom_we;
    logic [12:0] rom_address;
    logic [7:0]  rom_wdata;
    logic [7:0]  rom_rdata;
    logic        eeprom_we;
    logic        dirty_clear;
    logic        dirty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eeprom_save_bridge #(.ADDR_W(13), .RD_LAT(1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bridge_wr      (bridge_wr),
        .bridge_rd      (bridge_rd),
        .bridge_addr    (bridge_addr),
        .bridge_wr_data (bridge_wr_data),
        .bridge_rd_data (bridge_rd_data),
        .rd_valid       (rd_valid),
        .busy           (busy),
        .rom_we         (rom_we),
        .rom_address    (rom_address),
        .rom_wdata      (rom_wdata),
        .rom_rdata      (rom_rdata),
        .eeprom_we      (eeprom_we),
        .dirty_clear    (dirty_clear),
        .dirty          (dirty)
    );

    // Behavioural EEPROM backdoor: registered read, one cycle latency.
    logic [7:0] eep_mem [0:8191];
    always @(posedge clk) begin
        if (rom_we) eep_mem[rom_address] <= rom_wdata;
        rom_rdata <= eep_mem[rom_address];
    end

    // Count rd_valid pulses independently of the procedural checks.
    int rdv_cnt = 0;
    always @(posedge clk) begin
        if (rd_valid) rdv_cnt <= rdv_cnt + 1;
    end

    // Reference image of the save, byte addressed.
    logic [7:0] ref_mem [0:8191];
    logic       dirty_exp;
    logic [12:0] written_q[$];

    typedef struct {
        bit          is_wr;
        bit          both;
        logic [12:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [12:0] a);
        logic [12:0] b;
        b = {a[12:2], 2'b00};
        return {ref_mem[b + 13'd3], ref_mem[b + 13'd2], ref_mem[b + 13'd1], ref_mem[b]};
    endfunction

    // Word write; optionally raise bridge_rd with it and poke a second
    // request while busy. Checks every byte access cycle.
    task automatic do_write(input logic [12:0] addr, input logic [31:0] data,
                            input bit with_rd, input bit poke);
        logic [12:0] b;
        b = {addr[12:2], 2'b00};
        bridge_addr    = addr;
        bridge_wr_data = data;
        bridge_wr      = 1'b1;
        bridge_rd      = with_rd;
        step();
        bridge_wr = 1'b0;
        bridge_rd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            chk("wr_rom_we",   {31'd0, rom_we}, 32'd1);
            chk("wr_rom_addr", {19'd0, rom_address}, {19'd0, b + 13'(k)});
            chk("wr_rom_data", {24'd0, rom_wdata}, {24'd0, data[8*k +: 8]});
            chk("wr_busy",     {31'd0, busy}, 32'd1);
            if (poke && k == 1) begin
                bridge_wr      = 1'b1;
                bridge_rd      = 1'b1;
                bridge_addr    = 13'h0040;
                bridge_wr_data = 32'hFFFF_FFFF;
            end
            if (poke && k == 2) begin
                bridge_wr = 1'b0;
                bridge_rd = 1'b0;
            end
        end
        step();
        chk("wr_end_rom_we", {31'd0, rom_we}, 32'd0);
        chk("wr_end_busy",   {31'd0, busy}, 32'd0);
        chk("wr_dirty",      {31'd0, dirty}, {31'd0, dirty_exp});
        for (int i = 0; i < 4; i++) ref_mem[b + 13'(i)] = data[8*i +: 8];
        written_q.push_back(b);
        $display("write addr=0x%04h data=0x%08h", addr, data);
    endtask

    // Word read with full timing check: rd_valid expected 6 cycles after
    // the request cycle.
    task automatic do_read(input logic [12:0] addr, input logic [31:0] exp);
        logic [12:0] b;
        b = {addr[12:2], 2'b00};
        bridge_addr = addr;
        bridge_rd   = 1'b1;
        step();
        bridge_rd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            chk("rd_rom_addr", {19'd0, rom_address}, {19'd0, b + 13'(k)});
            chk("rd_rom_we",   {31'd0, rom_we}, 32'd0);
            chk("rd_busy",     {31'd0, busy}, 32'd1);
        end
        step();
        chk("rd_valid_early", {31'd0, rd_valid}, 32'd0);
        step();
        chk("rd_valid_pulse", {31'd0, rd_valid}, 32'd1);
        chk("rd_data",        bridge_rd_data, exp);
        step();
        chk("rd_valid_end",   {31'd0, rd_valid}, 32'd0);
        chk("rd_end_busy",    {31'd0, busy}, 32'd0);
        chk("rd_data_hold",   bridge_rd_data, exp);
        $display("read  addr=0x%04h data=0x%08h exp=0x%08h", addr, bridge_rd_data, exp);
    endtask

    initial begin
        int cnt0;
        reset_n        = 1'b0;
        bridge_wr      = 1'b0;
        bridge_rd      = 1'b0;
        bridge_addr    = 13'd0;
        bridge_wr_data = 32'd0;
        eeprom_we      = 1'b0;
        dirty_clear    = 1'b0;
        dirty_exp      = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 13'h0104, 32'hDDCC_BBAA, 32'h0,         "wr_0104"};
        vecs[1] = '{1'b0, 1'b0, 13'h0104, 32'h0,         32'hDDCC_BBAA, "rd_0104"};
        vecs[2] = '{1'b1, 1'b0, 13'h0000, 32'h5A5A_5A5A, 32'h0,         "wr_0000"};
        vecs[3] = '{1'b1, 1'b0, 13'h1FFF, 32'h4433_2211, 32'h0,         "wr_1fff"};
        vecs[4] = '{1'b0, 1'b0, 13'h1FFC, 32'h0,         32'h4433_2211, "rd_1ffc"};
        vecs[5] = '{1'b0, 1'b0, 13'h0002, 32'h0,         32'h5A5A_5A5A, "rd_0002"};
        vecs[6] = '{1'b1, 1'b1, 13'h0800, 32'hCAFE_F00D, 32'h0,         "wr_rd_0800"};
        vecs[7] = '{1'b0, 1'b0, 13'h0801, 32'h0,         32'hCAFE_F00D, "rd_0801"};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",     {31'd0, busy}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rom_we",   {31'd0, rom_we}, 32'd0);
        chk("rst_dirty",    {31'd0, dirty}, 32'd0);
        chk("rst_rom_addr", {19'd0, rom_address}, 32'd0);
        chk("rst_rom_data", {24'd0, rom_wdata}, 32'd0);
        chk("rst_rd_data",  bridge_rd_data, 32'd0);
        reset_n = 1'b1;
        step();

        // Directed vectors.
        for (int v = 0; v < 8; v++) begin
            $display("vector %0d %s", v, vecs[v].name);
            if (vecs[v].is_wr) begin
                cnt0 = rdv_cnt;
                do_write(vecs[v].addr, vecs[v].data, vecs[v].both, vecs[v].both);
                if (vecs[v].both) begin
                    repeat (8) begin
                        step();
                        chk("both_rom_we_idle", {31'd0, rom_we}, 32'd0);
                        chk("both_busy_idle",   {31'd0, busy}, 32'd0);
                    end
                    chk("both_no_rd_valid", rdv_cnt, cnt0);
                end
            end else begin
                do_read(vecs[v].addr, vecs[v].exp_rd);
            end
        end

        // Dirty flag sequence.
        eeprom_we = 1'b1;
        step();
        eeprom_we = 1'b0;
        chk("dirty_set", {31'd0, dirty}, 32'd1);
        eeprom_we   = 1'b1;
        dirty_clear = 1'b1;
        step();
        eeprom_we   = 1'b0;
        chk("dirty_set_wins", {31'd0, dirty}, 32'd1);
        step();
        dirty_clear = 1'b0;
        chk("dirty_cleared", {31'd0, dirty}, 32'd0);
        $display("dirty sequence done dirty=%0b", dirty);
        dirty_exp = 1'b0;

        // Reset after two bytes of a write.
        do_write(13'h0200, 32'h1122_3344, 1'b0, 1'b0);
        bridge_addr    = 13'h0200;
        bridge_wr_data = 32'hAABB_CCDD;
        bridge_wr      = 1'b1;
        step();
        bridge_wr = 1'b0;
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_rom_we", {31'd0, rom_we}, 32'd0);
        chk("rst_mid_busy",   {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        step();
        chk("rst_after_busy", {31'd0, busy}, 32'd0);
        ref_mem[13'h0200] = 8'hDD;
        ref_mem[13'h0201] = 8'hCC;
        $display("reset mid-write done");
        do_read(13'h0200, ref_word(13'h0200));

        // Randomised traffic against the reference image.
        for (int it = 0; it < 40; it++) begin
            int gaps;
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                eeprom_we   = ($urandom_range(0, 3) == 0);
                dirty_clear = ($urandom_range(0, 2) == 0);
                step();
                if (eeprom_we) dirty_exp = 1'b1;
                else if (dirty_clear) dirty_exp = 1'b0;
                chk("rand_dirty", {31'd0, dirty}, {31'd0, dirty_exp});
                eeprom_we   = 1'b0;
                dirty_clear = 1'b0;
            end
            if (written_q.size() == 0 || $urandom_range(0, 1) == 0) begin
                do_write(13'($urandom_range(0, 8191)), $urandom, 1'b0, 1'b0);
            end else begin
                logic [12:0] a;
                a = written_q[$urandom_range(0, written_q.size() - 1)] | 13'($urandom_range(0, 3));
                do_read(a, ref_word(a));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
